sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one downstream SRAM-like bus between the CPU's instruction-fetch requester (IF stage) and data requester (EXE/MEM stages). It sits between mycpu_top and the memory/bridge.
- Arbitrates requests and holds each grant until the address handshake completes.
- Records the issue order of accepted requests in a small ID FIFO, and uses it to route in-order data_ok/rdata back to the correct requester.

Parameters:
- DEPTH, 4, maximum outstanding accepted-but-unanswered transactions; power of 2, at least 2.
- PTR_W, 2, log2(DEPTH); FIFO pointer width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- inst_sram_req/wr  in  1/1  instruction-port request and write flag.
- inst_sram_size  in  2  instruction-port transfer size.
- inst_sram_wstrb  in  4  instruction-port byte strobes.
- inst_sram_addr/wdata  in  32/32  instruction-port address and write data.
- inst_sram_addr_ok/data_ok  out  1/1  instruction-port address and data handshakes.
- inst_sram_rdata  out  32  instruction-port read data.
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data-port request fields.
- data_sram_addr_ok/data_ok  out  1/1  data-port handshakes.
- data_sram_rdata  out  32  data-port read data.
- mem_req/wr  out  1/1  downstream request and write flag.
- mem_size  out  2  downstream transfer size.
- mem_wstrb  out  4  downstream byte strobes.
- mem_addr/wdata  out  32/32  downstream address and write data.
- mem_addr_ok/data_ok  in  1/1  downstream handshakes.
- mem_rdata  in  32  downstream read data.
- outstanding_cnt  out  PTR_W+1  number of entries currently held in the ID FIFO.

Behaviour:
- Reset (asynchronous, resetn=0): FSM=IDLE, FIFO empty, outstanding_cnt=0. All handshake outputs deassert immediately: mem_req, both addr_ok, both data_ok = 0. Any in-flight responses are forgotten.
- FSM states: IDLE, LOCK_I, LOCK_D.
- sel (grant) is combinational:
  - IDLE: sel=D if data_sram_req, else I if inst_sram_req. Data has fixed priority.
  - LOCK_I: sel=I.
  - LOCK_D: sel=D.
- full = (outstanding_cnt==DEPTH).
- mem_req = selected requester's req & ~full. mem_wr/size/wstrb/addr/wdata mux from sel.
  - In IDLE with no request, the mux defaults to inst fields and mem_req=0.
- addr_ok routing: <sel>_sram_addr_ok = mem_addr_ok & mem_req; the other port's addr_ok = 0. mem_addr_ok is passed through combinationally, with no added latency.
- Accept = mem_req & mem_addr_ok. On accept, push sel's ID (0=I, 1=D) into the FIFO.
- FSM transitions:
  - IDLE -> LOCK_x when mem_req & ~mem_addr_ok. The grant freezes, so the downstream request fields stay stable until the handshake.
  - LOCK_x -> IDLE on accept.
  - LOCK_x stays put while full. In LOCK_x, a requester dropping req is a protocol violation; behaviour is undefined.
- Response routing:
  - On mem_data_ok with FIFO non-empty, pop the head. The head ID selects which port's data_ok=1, same cycle.
  - rdata = mem_rdata broadcast to both ports.
  - mem_data_ok with FIFO empty is ignored: no data_ok output, no state change.
- Simultaneous push and pop: both occur; outstanding_cnt unchanged; ordering preserved.
- full is evaluated from the registered count. A pop in the same cycle does not unmask mem_req; the request issues the next cycle.
- Pointers wrap modulo DEPTH; outstanding_cnt is the registered occupancy.
- Latency:
  - Request path: 0 cycles (combinational).
  - Response path: 0 cycles.
  - Back-to-back accepts are possible every cycle while not full.

Test Plan:
1. Inst fetch only: inst_req=1, inst_addr=0xBFC00000, mem_addr_ok=1 at cycle 0; mem_data_ok=1, mem_rdata=0x3C1D0000 at cycle 2. Required: mem_addr=0xBFC00000 at cycle 0; inst_sram_data_ok=1 with rdata 0x3C1D0000 at cycle 2; data_sram_data_ok=0 throughout; outstanding_cnt goes 0->1->0.
2. Simultaneous requests: data_req (wr=1, addr=0x80001000, wstrb=0xF) and inst_req (addr=0xBFC00004) both high, mem_addr_ok=1. Required: cycle 0 issues the data request (mem_wr=1); cycle 1 issues the inst request. Two later data_ok pulses route to data first, then inst.
3. Grant lock: inst_req at cycle 0 with mem_addr_ok=0 for cycles 0-2; data_req rises at cycle 1; mem_addr_ok=1 at cycle 3. Required: mem_addr=inst addr for cycles 0-3 and inst_addr_ok=1 at cycle 3; the data request is issued at cycle 4.
4. Full: DEPTH=4, four accepted requests with no data_ok, then a fifth inst_req. Required: mem_req=0 and outstanding_cnt=4. When mem_data_ok arrives (cycle k), the fifth request is issued at cycle k+1.
5. Reset mid-operation: 3 outstanding, resetn=0 between clock edges. Required: outstanding_cnt=0 and mem_req=0 immediately. A mem_data_ok after reset release produces no data_ok on either port.
6. Spurious response: FIFO empty, mem_data_ok=1. Required: inst_data_ok=data_data_ok=0; outstanding_cnt stays 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-master SRAM-like bus arbiter: data port has fixed priority, a grant is held until its
// address handshake, and an ID FIFO routes in-order responses back to the issuing port.
module sram_like_arbiter #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_sram_req,
   input  logic              inst_sram_wr,
   input  logic [1:0]        inst_sram_size,
   input  logic [3:0]        inst_sram_wstrb,
   input  logic [31:0]       inst_sram_addr,
   input  logic [31:0]       inst_sram_wdata,
   output logic              inst_sram_addr_ok,
   output logic              inst_sram_data_ok,
   output logic [31:0]       inst_sram_rdata,

   input  logic              data_sram_req,
   input  logic              data_sram_wr,
   input  logic [1:0]        data_sram_size,
   input  logic [3:0]        data_sram_wstrb,
   input  logic [31:0]       data_sram_addr,
   input  logic [31:0]       data_sram_wdata,
   output logic              data_sram_addr_ok,
   output logic              data_sram_data_ok,
   output logic [31:0]       data_sram_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [31:0]       mem_rdata,

   output logic [PTR_W:0]    outstanding_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_I = 2'd1,
      LOCK_D = 2'd2
   } state_e;

   localparam logic            ID_I     = 1'b0;
   localparam logic            ID_D     = 1'b1;
   localparam logic [PTR_W:0]  FULL_CNT = DEPTH[PTR_W:0];

   state_e              state_q;
   logic [DEPTH-1:0]    id_mem_q;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]      cnt_q, cnt_d;

   logic                sel;
   logic                sel_req;
   logic                full;
   logic                accept;
   logic                pop;
   logic                head_id;

   // Grant: a locked state freezes the selection until the address handshake.
   always_comb begin
      unique case (state_q)
         LOCK_I:  sel = ID_I;
         LOCK_D:  sel = ID_D;
         default: sel = data_sram_req ? ID_D : ID_I;
      endcase
   end

   assign sel_req = (sel == ID_D) ? data_sram_req : inst_sram_req;
   assign full    = (cnt_q == FULL_CNT);

   // Qualified with resetn so no request leaks downstream while reset is asserted.
   assign mem_req   = resetn & sel_req & ~full;
   assign mem_wr    = (sel == ID_D) ? data_sram_wr    : inst_sram_wr;
   assign mem_size  = (sel == ID_D) ? data_sram_size  : inst_sram_size;
   assign mem_wstrb = (sel == ID_D) ? data_sram_wstrb : inst_sram_wstrb;
   assign mem_addr  = (sel == ID_D) ? data_sram_addr  : inst_sram_addr;
   assign mem_wdata = (sel == ID_D) ? data_sram_wdata : inst_sram_wdata;

   assign accept            = mem_req & mem_addr_ok;
   assign inst_sram_addr_ok = accept & (sel == ID_I);
   assign data_sram_addr_ok = accept & (sel == ID_D);

   assign head_id           = id_mem_q[rd_ptr_q];
   assign pop               = mem_data_ok & (cnt_q != '0);
   assign inst_sram_data_ok = pop & (head_id == ID_I);
   assign data_sram_data_ok = pop & (head_id == ID_D);
   assign inst_sram_rdata   = mem_rdata;
   assign data_sram_rdata   = mem_rdata;

   assign outstanding_cnt   = cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE:           if (mem_req && !mem_addr_ok) state_q <= (sel == ID_D) ? LOCK_D : LOCK_I;
            LOCK_I, LOCK_D: if (accept) state_q <= IDLE;
            default:        state_q <= IDLE;
         endcase
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({accept, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: the ID storage has no reset; only the pointers and count decide which entries are live.
   always_ff @(posedge clk) begin
      if (accept) id_mem_q[wr_ptr_q] <= sel;
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a queue-based model of the arbitration rules.
module tb_sram_like_arbiter;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   logic        i_req = 0, i_wr = 0;
   logic [1:0]  i_size = 0;
   logic [3:0]  i_wstrb = 0;
   logic [31:0] i_addr = 0, i_wdata = 0;
   logic        d_req = 0, d_wr = 0;
   logic [1:0]  d_size = 0;
   logic [3:0]  d_wstrb = 0;
   logic [31:0] d_addr = 0, d_wdata = 0;
   logic        mem_addr_ok = 0, mem_data_ok = 0;
   logic [31:0] mem_rdata = 0;

   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic [PTR_W:0] outstanding_cnt;

   sram_like_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(i_req), .inst_sram_wr(i_wr), .inst_sram_size(i_size),
      .inst_sram_wstrb(i_wstrb), .inst_sram_addr(i_addr), .inst_sram_wdata(i_wdata),
      .inst_sram_addr_ok(inst_addr_ok), .inst_sram_data_ok(inst_data_ok), .inst_sram_rdata(inst_rdata),
      .data_sram_req(d_req), .data_sram_wr(d_wr), .data_sram_size(d_size),
      .data_sram_wstrb(d_wstrb), .data_sram_addr(d_addr), .data_sram_wdata(d_wdata),
      .data_sram_addr_ok(data_addr_ok), .data_sram_data_ok(data_data_ok), .data_sram_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .outstanding_cnt(outstanding_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit  mq[$];          // issue order of unanswered requests: 0 = inst, 1 = data
   int  lock = -1;      // port a pending handshake is frozen on, -1 when free
   bit  chk_en = 0;
   bit  pend_valid = 0, pend_push = 0, pend_pop = 0, pend_id = 0;
   int  pend_lock = -1;
   bit  last_acc_i = 0, last_acc_d = 0;

   int          m_sel;
   logic        m_req, m_full, m_acc, m_pop, m_head;
   logic [70:0] m_fields;

   always @(negedge clk) begin
      last_acc_i = 0;
      last_acc_d = 0;
      if (chk_en) begin
         if (!resetn) begin
            pend_valid = 0;
            check("rst_handshakes", 72'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 72'(0));
            check("rst_cnt", 72'(outstanding_cnt), 72'(0));
         end else begin
            m_full = (mq.size() == DEPTH);
            m_sel  = (lock >= 0) ? lock : (d_req ? 1 : 0);
            m_req  = ((m_sel == 1) ? d_req : i_req) && !m_full;
            m_fields = (m_sel == 1) ? {d_wr, d_size, d_wstrb, d_addr, d_wdata}
                                    : {i_wr, i_size, i_wstrb, i_addr, i_wdata};
            m_acc  = m_req && mem_addr_ok;
            m_pop  = mem_data_ok && (mq.size() > 0);
            m_head = (mq.size() > 0) ? mq[0] : 1'b0;
            check("handshakes", 72'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}),
                  72'({m_req, m_acc && m_sel == 0, m_acc && m_sel == 1, m_pop && !m_head, m_pop && m_head}));
            check("fields", 72'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}), 72'(m_fields));
            check("rdata", 72'({inst_rdata, data_rdata}), 72'({mem_rdata, mem_rdata}));
            check("cnt", 72'(outstanding_cnt), 72'(mq.size()));
            pend_valid = 1;
            pend_push  = m_acc;
            pend_id    = (m_sel == 1);
            pend_pop   = m_pop;
            pend_lock  = m_acc ? -1 : (m_req ? m_sel : lock);
            last_acc_i = m_acc && m_sel == 0;
            last_acc_d = m_acc && m_sel == 1;
         end
      end
   end

   always @(posedge clk) begin
      if (resetn && pend_valid) begin
         if (pend_pop)  void'(mq.pop_front());
         if (pend_push) mq.push_back(pend_id);
         lock       = pend_lock;
         pend_valid = 0;
      end
   end

   always @(negedge resetn) begin
      mq.delete();
      lock       = -1;
      pend_valid = 0;
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_req = 0; i_wr = 0; i_size = 0; i_wstrb = 0; i_addr = 0; i_wdata = 0;
      d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   // Requesters hold a request until its address handshake, then may start a new one.
   task automatic drive_rand(input int p_start, input int p_aok, input int p_dok);
      if (!i_req || last_acc_i) begin
         i_req   = ($urandom_range(0, 99) < p_start);
         i_wr    = 1'($urandom);
         i_size  = 2'($urandom);
         i_wstrb = 4'($urandom);
         i_addr  = $urandom;
         i_wdata = $urandom;
      end
      if (!d_req || last_acc_d) begin
         d_req   = ($urandom_range(0, 99) < p_start);
         d_wr    = 1'($urandom);
         d_size  = 2'($urandom);
         d_wstrb = 4'($urandom);
         d_addr  = $urandom;
         d_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 99) < p_aok);
      mem_data_ok = ($urandom_range(0, 99) < p_dok);
      mem_rdata   = $urandom;
   endtask

   initial begin
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      chk_en = 1;

      // Spurious response with nothing outstanding.
      cyc(); mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
      neg(); check("spur_dok", 72'({inst_data_ok, data_data_ok}), 72'(0));
      cyc(); mem_data_ok = 0;
      neg(); check("spur_cnt", 72'(outstanding_cnt), 72'(0));

      // Instruction fetch only.
      cyc(); i_req = 1; i_addr = 32'hBFC0_0000; mem_addr_ok = 1;
      neg(); check("t1_addr", 72'({mem_req, mem_addr}), 72'({1'b1, 32'hBFC0_0000}));
             check("t1_cnt0", 72'(outstanding_cnt), 72'(0));
      cyc(); i_req = 0; mem_addr_ok = 0;
      neg(); check("t1_cnt1", 72'(outstanding_cnt), 72'(1));
      cyc(); mem_data_ok = 1; mem_rdata = 32'h3C1D_0000;
      neg(); check("t1_resp", 72'({inst_data_ok, data_data_ok, inst_rdata}), 72'({2'b10, 32'h3C1D_0000}));
      cyc(); mem_data_ok = 0;
      neg(); check("t1_cnt2", 72'(outstanding_cnt), 72'(0));

      // Simultaneous requests: data wins, inst follows, responses in issue order.
      cyc(); d_req = 1; d_wr = 1; d_addr = 32'h8000_1000; d_wstrb = 4'hF;
             i_req = 1; i_addr = 32'hBFC0_0004; mem_addr_ok = 1;
      neg(); check("t2_first", 72'({mem_wr, mem_addr, data_addr_ok, inst_addr_ok}), 72'({1'b1, 32'h8000_1000, 2'b10}));
      cyc(); d_req = 0; d_wr = 0;
      neg(); check("t2_second", 72'({mem_wr, mem_addr, data_addr_ok, inst_addr_ok}), 72'({1'b0, 32'hBFC0_0004, 2'b01}));
      cyc(); i_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_1111;
      neg(); check("t2_resp_d", 72'({data_data_ok, inst_data_ok}), 72'(2'b10));
      cyc(); mem_rdata = 32'h2222_2222;
      neg(); check("t2_resp_i", 72'({data_data_ok, inst_data_ok}), 72'(2'b01));
      cyc(); mem_data_ok = 0;

      // Grant lock: a later data request cannot steal an unacknowledged inst grant.
      cyc(); i_req = 1; i_addr = 32'hBFC0_0100; mem_addr_ok = 0;
      neg(); check("t3_c0", 72'({mem_addr, inst_addr_ok}), 72'({32'hBFC0_0100, 1'b0}));
      cyc(); d_req = 1; d_addr = 32'h8000_2000;
      neg(); check("t3_c1", 72'(mem_addr), 72'(32'hBFC0_0100));
      cyc();
      neg(); check("t3_c2", 72'(mem_addr), 72'(32'hBFC0_0100));
      cyc(); mem_addr_ok = 1;
      neg(); check("t3_c3", 72'({mem_addr, inst_addr_ok, data_addr_ok}), 72'({32'hBFC0_0100, 2'b10}));
      cyc(); i_req = 0;
      neg(); check("t3_c4", 72'({mem_addr, data_addr_ok}), 72'({32'h8000_2000, 1'b1}));
      cyc(); d_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      cyc();
      cyc(); mem_data_ok = 0;
      neg(); check("t3_drain", 72'(outstanding_cnt), 72'(0));

      // Full FIFO masks the request until a pop has been registered.
      for (int n = 0; n < DEPTH; n++) begin
         cyc(); i_req = 1; i_addr = 32'h1000_0000 + 32'(4 * n); mem_addr_ok = 1;
      end
      cyc(); i_addr = 32'h1000_0100;
      neg(); check("t4_full", 72'({mem_req, inst_addr_ok, outstanding_cnt}), 72'({2'b00, 3'(DEPTH)}));
      cyc(); mem_data_ok = 1;
      neg(); check("t4_pop_same", 72'({mem_req, inst_data_ok}), 72'(2'b01));
      cyc(); mem_data_ok = 0;
      neg(); check("t4_issue", 72'({mem_req, inst_addr_ok, mem_addr, outstanding_cnt}),
                   72'({2'b11, 32'h1000_0100, 3'(DEPTH - 1)}));
      cyc(); i_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      cyc(); mem_data_ok = 0; i_req = 1; i_addr = 32'h1000_0200;
      neg(); check("t5_pre", 72'({mem_req, outstanding_cnt}), 72'({1'b1, 3'd3}));

      // Asynchronous reset in the middle of traffic.
      @(posedge clk); #3 resetn = 0;
      #1 check("t5_async", 72'({mem_req, inst_addr_ok, outstanding_cnt}), 72'(0));
      cyc(); i_req = 0;
      cyc(); resetn = 1;
      cyc(); mem_data_ok = 1;
      neg(); check("t5_post_dok", 72'({inst_data_ok, data_data_ok, outstanding_cnt}), 72'(0));
      cyc(); mem_data_ok = 0;

      // Randomized traffic: balanced, then slow responses to exercise the full condition.
      repeat (2000) begin cyc(); drive_rand(40, 60, 50); end
      repeat (1500) begin cyc(); drive_rand(60, 70, 15); end
      repeat (16)   begin cyc(); drive_rand(0, 100, 100); end
      cyc(); idle_inputs();
      neg(); check("final_drain", 72'(outstanding_cnt), 72'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
